// File: rtl/state_sequencer.sv
// state_sequencer
// Steps through a table of state codes held in an external synchronous memory.
// Each entry is held for DWELL running cycles. The run can be paused, rewound,
// looped, or stopped after the last entry (one-shot mode).
//
// Ports
//   CLK          clock, all logic on the rising edge
//   RESET_N      asynchronous active-low reset
//   EN           run enable (0 pauses the dwell count)
//   ONE_SHOT     1 = stop after the last entry, 0 = loop
//   RESTART      single-cycle pulse, rewinds to entry 0
//   MEM_ADDR     registered address to the external memory
//   MEM_Q        memory read data, valid one cycle after MEM_ADDR
//   CurrentState registered state code (illegal codes map to 0)
//   STEP         one-cycle pulse on each address advance
//   DONE         high while a one-shot sequence is complete
module state_sequencer #(
  parameter int unsigned STATE_W    = 3,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned DWELL      = 26
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               EN,
  input  logic               ONE_SHOT,
  input  logic               RESTART,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic [STATE_W-1:0] MEM_Q,
  output logic [STATE_W-1:0] CurrentState,
  output logic               STEP,
  output logic               DONE
);

  localparam int unsigned CntW = (DWELL > 2) ? $clog2(DWELL) : 1;

  localparam logic [CntW-1:0]    CntLast      = CntW'(DWELL - 1);
  localparam logic [ADDR_W-1:0]  AddrLast     = ADDR_W'(DEPTH - 1);
  localparam logic [STATE_W:0]   NumStatesExt = (STATE_W + 1)'(NUM_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StFin
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            state_legal;

  // Extra top bit lets NUM_STATES = 2**STATE_W compare correctly.
  assign state_legal = ({1'b0, MEM_Q} < NumStatesExt);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      MEM_ADDR <= '0;
      STEP     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      STEP <= 1'b0;
      if (RESTART) begin
        // Rewind wins over any dwell expiry in the same cycle.
        cnt_q    <= '0;
        MEM_ADDR <= '0;
        DONE     <= 1'b0;
        state_q  <= EN ? StRun : StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (EN) state_q <= StRun;
          end
          StRun: begin
            if (cnt_q == CntLast) begin
              // Expiry completes even if EN just fell; pause afterwards.
              cnt_q <= '0;
              if ((MEM_ADDR == AddrLast) && ONE_SHOT) begin
                state_q <= StFin;
                DONE    <= 1'b1;
              end else begin
                MEM_ADDR <= (MEM_ADDR == AddrLast) ? '0 : MEM_ADDR + 1'b1;
                STEP     <= 1'b1;
                if (!EN) state_q <= StPause;
              end
            end else if (EN) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= StPause;
            end
          end
          StPause: begin
            if (EN) state_q <= StRun;
          end
          StFin: begin
            DONE <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Decode stage: memory data is registered every cycle regardless of FSM state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CurrentState <= '0;
    end else begin
      CurrentState <= state_legal ? MEM_Q : '0;
    end
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The block SHALL have parameter STATE_W, default 3, giving the width of memory words and of CurrentState.
REQ-002 The block SHALL have parameter ADDR_W, default 2, giving the memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the number of sequence entries (2..2^ADDR_W).
REQ-004 The block SHALL have parameter NUM_STATES, default 4, giving the count of legal state codes (0..NUM_STATES-1).
REQ-005 The block SHALL have parameter DWELL, default 26, giving the clock cycles spent on each entry (>=2).
REQ-006 Port CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-007 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-008 Port EN, input, 1: run enable.
REQ-009 Port ONE_SHOT, input, 1: 1 = stop after the last entry; 0 = loop.
REQ-010 Port RESTART, input, 1: single-cycle pulse that rewinds the sequence to entry 0.
REQ-011 Port MEM_ADDR, output, ADDR_W: registered address to the external synchronous memory.
REQ-012 Port MEM_Q, input, STATE_W: memory data, valid 1 cycle after MEM_ADDR.
REQ-013 Port CurrentState, output, STATE_W: registered decoded state code.
REQ-014 Port STEP, output, 1: 1-cycle pulse on each address advance.
REQ-015 Port DONE, output, 1: high while one-shot sequence complete.

Function
REQ-016 The control FSM SHALL have states IDLE, RUN, PAUSE and FIN.
- IDLE->RUN when EN=1.
- RUN->PAUSE when EN=0.
- PAUSE->RUN when EN=1.
- RUN->FIN on the last-entry dwell expiry when ONE_SHOT=1.
- FIN->RUN on RESTART with EN=1.
- FIN->IDLE on RESTART with EN=0.
REQ-017 The dwell counter SHALL count 0..DWELL-1 only in RUN, and SHALL hold its value in IDLE, PAUSE and FIN.
REQ-018 In RUN with the counter at DWELL-1, the counter SHALL go to 0, STEP SHALL pulse for 1 cycle, and MEM_ADDR SHALL advance by 1.
REQ-019 At the address-advance point of REQ-018, MEM_ADDR=DEPTH-1 SHALL wrap to 0 when ONE_SHOT=0.
REQ-020 At the address-advance point of REQ-018, with MEM_ADDR=DEPTH-1 and ONE_SHOT=1, MEM_ADDR SHALL hold at DEPTH-1, the FSM SHALL enter FIN, DONE SHALL go to 1, and STEP SHALL NOT pulse.
REQ-021 Each entry SHALL be held for exactly DWELL RUN cycles, and pause cycles SHALL NOT count toward the dwell.
REQ-022 Every cycle, CurrentState SHALL load MEM_Q when MEM_Q<NUM_STATES, else 0 (idle code).
REQ-023 CurrentState SHALL change 2 cycles after a MEM_ADDR change (1 cycle memory read plus 1 register stage).
REQ-024 RESTART SHALL set MEM_ADDR=0, counter=0 and DONE=0 in any FSM state; the next state SHALL be RUN if EN=1, else IDLE.
REQ-025 RESTART SHALL take priority over a simultaneous dwell expiry, and no STEP SHALL occur in that cycle.
REQ-026 EN falling in the same cycle as a dwell expiry SHALL still complete that advance and pulse STEP, then enter PAUSE.
REQ-027 Changes to ONE_SHOT SHALL take effect at the next last-entry expiry.

Reset
REQ-028 While RESET_N=0, the block SHALL immediately force FSM=IDLE, counter=0, MEM_ADDR=0, CurrentState=0, STEP=0 and DONE=0, independent of CLK.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence, and operation after release SHALL restart from entry 0 only when EN=1.

Verification
REQ-030 The bench SHALL cover each of the following scenarios, using DWELL=4, DEPTH=4, NUM_STATES=4 and memory {1,2,3,7}:
- Loop: EN=1, ONE_SHOT=0 -> MEM_ADDR 0,1,2,3,0 each held for 4 cycles; CurrentState 1,2,3,0,1 lagging MEM_ADDR by 2 cycles; STEP once per 4 cycles.
- One-shot: ONE_SHOT=1 -> after entry 3 for 4 cycles, DONE=1, MEM_ADDR stays 3, no further STEP; RESTART with EN=1 -> MEM_ADDR=0, DONE=0, RUN.
- Pause: EN=0 for 10 cycles at counter=2 -> MEM_ADDR and counter frozen; after EN=1, advance occurs 2 cycles later.
- Collision: RESTART in the counter=3 cycle -> MEM_ADDR=0, no STEP; EN falls at counter=3 -> advance plus STEP, then PAUSE.
- Reset: RESET_N low between clock edges mid-run -> all outputs 0 immediately; after release with EN=0, stays IDLE with MEM_ADDR=0.
- Illegal code: MEM_Q=7 -> CurrentState=0.
